// File: rtl/boot_pkg.sv
// rtl/boot_pkg.sv - shared types and widths for the instruction-memory boot loader
//
// Purpose: loader FSM state encoding and the byte/word widths used by the
// loader, its byte packer and its bus interface.
package boot_pkg;

    localparam int WORD_W = 32;
    localparam int BYTE_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        LOAD,
        CSUM,
        DONE,
        ERR
    } state_t;

endpackage

// File: rtl/imem_boot_loader_if.sv
// rtl/imem_boot_loader_if.sv - byte stream, imem write port and status bundle of the boot loader
//
// Purpose: groups every non-clock signal of the loader.
// Ports (signals):
//   start              arm/restart pulse
//   s_data/s_valid     image byte stream in, s_ready back-pressure out
//   imem_we/addr/wdata instruction memory write port
//   cpu_run/done/err   core release and load status
// Modports: master = image source / system side, slave = loader.
interface imem_boot_loader_if
    import boot_pkg::*;
#(
    parameter int ADDR_W = 32
) ();

    logic              start;
    logic [BYTE_W-1:0] s_data;
    logic              s_valid;
    logic              s_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [WORD_W-1:0] imem_wdata;
    logic              cpu_run;
    logic              done;
    logic              err;

    modport master (
        output start, s_data, s_valid,
        input  s_ready, imem_we, imem_addr, imem_wdata, cpu_run, done, err
    );

    modport slave (
        input  start, s_data, s_valid,
        output s_ready, imem_we, imem_addr, imem_wdata, cpu_run, done, err
    );

endinterface

// File: rtl/byte_word_packer.sv
// rtl/byte_word_packer.sv - 8-to-32 bit little-endian word assembler
//
// Purpose: collects accepted bytes into a word, byte0 landing in bits [7:0].
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   clear_i         drop any partial word (loader restart)
//   byte_valid_i    a byte is transferred this cycle
//   byte_i          the transferred byte
//   word_valid_o    this transfer is the 4th byte of a word
//   word_o          assembled word, valid with word_valid_o
module byte_word_packer
    import boot_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear_i,
    input  logic              byte_valid_i,
    input  logic [BYTE_W-1:0] byte_i,
    output logic              word_valid_o,
    output logic [WORD_W-1:0] word_o
);

    logic [1:0]          cnt_q;
    logic [3*BYTE_W-1:0] acc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 2'd0;
            acc_q <= '0;
        end else if (clear_i) begin
            cnt_q <= 2'd0;
        end else if (byte_valid_i) begin
            // 2-bit counter wraps 3->0 on its own after the 4th byte
            cnt_q <= cnt_q + 2'd1;
            case (cnt_q)
                2'd0:    acc_q[7:0]   <= byte_i;
                2'd1:    acc_q[15:8]  <= byte_i;
                2'd2:    acc_q[23:16] <= byte_i;
                default: ;
            endcase
        end
    end

    // The word is presented combinationally on its 4th byte so the loader can
    // act on the handshake edge itself rather than one cycle later.
    assign word_valid_o = byte_valid_i && (cnt_q == 2'd3);
    assign word_o       = {byte_i, acc_q};

endmodule

// File: rtl/imem_boot_loader.sv
// rtl/imem_boot_loader.sv - streams a program image into instruction memory, then releases the core
//
// Purpose: parses frame {N (LE32), N payload words (LE32), [checksum (LE32)]},
// writes each payload word to BASE_ADDR + 4*idx and raises cpu_run once the
// image is in place.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   boot_if     imem_boot_loader_if.slave: start, s_data/s_valid/s_ready,
//               imem_we/imem_addr/imem_wdata, cpu_run, done, err
// Build option: BOOT_CHECKSUM_EN adds the XOR checksum trailer check.
module imem_boot_loader
    import boot_pkg::*;
#(
    parameter int                IMEM_WORDS = 64,
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = '0
) (
    input logic               clk,
    input logic               rst_n,
    imem_boot_loader_if.slave boot_if
);

    localparam int IDX_W = $clog2(IMEM_WORDS + 1);

`ifdef BOOT_CHECKSUM_EN
    localparam state_t AFTER_LOAD = CSUM;
`else
    localparam state_t AFTER_LOAD = DONE;
`endif

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [IDX_W-1:0]  len_q, len_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;
    logic              run_q, run_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
`ifdef BOOT_CHECKSUM_EN
    logic [WORD_W-1:0] csum_q, csum_d;
`endif

    logic              ready_state;
    logic              accept;
    logic              word_valid;
    logic [WORD_W-1:0] word;

    assign ready_state = (state_q == LEN) || (state_q == LOAD) || (state_q == CSUM);
    // A start pulse owns its cycle: no byte may slip in ahead of the new frame.
    assign boot_if.s_ready = ready_state && !boot_if.start;
    assign accept          = boot_if.s_ready && boot_if.s_valid;

    byte_word_packer u_packer (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear_i      (boot_if.start),
        .byte_valid_i (accept),
        .byte_i       (boot_if.s_data),
        .word_valid_o (word_valid),
        .word_o       (word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            len_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= BASE_ADDR;
            wdata_q <= '0;
            run_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            run_q   <= run_d;
            done_q  <= done_d;
            err_q   <= err_d;
`ifdef BOOT_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        len_d   = len_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        run_d   = run_q;
        done_d  = done_q;
        err_d   = err_q;
`ifdef BOOT_CHECKSUM_EN
        csum_d  = csum_q;
`endif
        if (boot_if.start) begin
            state_d = LEN;
            idx_d   = '0;
            len_d   = '0;
            run_d   = 1'b0;
            done_d  = 1'b0;
            err_d   = 1'b0;
`ifdef BOOT_CHECKSUM_EN
            csum_d  = '0;
`endif
        end else begin
            case (state_q)
                LEN: begin
                    if (word_valid) begin
                        if (word > WORD_W'(IMEM_WORDS)) begin
                            state_d = ERR;
                        end else begin
                            len_d   = word[IDX_W-1:0];
                            state_d = (word == '0) ? AFTER_LOAD : LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (word_valid) begin
                        // Write is registered: the strobe appears the cycle after
                        // the 4th byte, together with the state change below.
                        we_d    = 1'b1;
                        wdata_d = word;
                        addr_d  = BASE_ADDR + (ADDR_W'(idx_q) << 2);
                        idx_d   = idx_q + IDX_W'(1);
`ifdef BOOT_CHECKSUM_EN
                        csum_d  = csum_q ^ word;
`endif
                        if (idx_q + IDX_W'(1) == len_q) begin
                            state_d = AFTER_LOAD;
                        end
                    end
                end
`ifdef BOOT_CHECKSUM_EN
                CSUM: begin
                    if (word_valid) begin
                        state_d = (word == csum_q) ? DONE : ERR;
                    end
                end
`endif
                DONE: begin
                    done_d = 1'b1;
                    run_d  = 1'b1;
                end
                ERR: begin
                    err_d = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign boot_if.imem_we    = we_q;
    assign boot_if.imem_addr  = addr_q;
    assign boot_if.imem_wdata = wdata_q;
    assign boot_if.cpu_run    = run_q;
    assign boot_if.done       = done_q;
    assign boot_if.err        = err_q;

endmodule
